// File: rtl/pc_checkpoint_monitor_if.sv
// Configuration, golden-store load and DM probe signals of the checkpoint monitor.
interface pc_checkpoint_monitor_if #(
    parameter int unsigned bit_size = 32,
    parameter int unsigned mem_size = 16,
    parameter int unsigned NUM_CP   = 4,
    parameter int unsigned DEPTH    = 128
);
    localparam int unsigned CPW = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;
    localparam int unsigned GAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                cfg_we;
    logic [CPW-1:0]      cfg_idx;
    logic [mem_size-1:0] cfg_pc;
    logic [mem_size-1:0] cfg_lo;
    logic [mem_size-1:0] cfg_hi;
    logic                gold_we;
    logic [GAW-1:0]      gold_addr;
    logic [bit_size-1:0] gold_data;
    logic [mem_size-1:0] chk_addr;
    logic [bit_size-1:0] chk_data;

    // Bench/DM side: loads tables, answers DM probes.
    modport master (
        output cfg_we, cfg_idx, cfg_pc, cfg_lo, cfg_hi,
        output gold_we, gold_addr, gold_data,
        output chk_data,
        input  chk_addr
    );

    // Monitor side.
    modport slave (
        input  cfg_we, cfg_idx, cfg_pc, cfg_lo, cfg_hi,
        input  gold_we, gold_addr, gold_data,
        input  chk_data,
        output chk_addr
    );
endinterface

// File: rtl/pc_checkpoint_monitor.sv
// Watches fetch PCs against an ordered checkpoint list and scans a DM window
// against a golden store at each checkpoint; watchdog flags a hung program.
module pc_checkpoint_monitor #(
    parameter int unsigned bit_size = 32,
    parameter int unsigned mem_size = 16,
    parameter int unsigned NUM_CP   = 4,
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned TIMEOUT  = 1000,
    localparam int unsigned CPW     = (NUM_CP > 1) ? $clog2(NUM_CP) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [mem_size-1:0]   IM_Address,
    pc_checkpoint_monitor_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CPW-1:0]        cur_cp,
    output logic [CPW-1:0]        fail_cp,
    output logic [15:0]           err_cnt,
    output logic [mem_size-1:0]   first_err_addr
);
    localparam int unsigned GAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_CP, S_SCAN, S_EVAL, S_PASS, S_FAIL, S_TMO
    } state_t;

    typedef struct packed {
        logic [mem_size-1:0] pc;
        logic [mem_size-1:0] lo;
        logic [mem_size-1:0] hi;
    } cp_t;

    cp_t                 cp_tab   [NUM_CP];
    logic [bit_size-1:0] gold_mem [DEPTH];

    state_t              state_q, state_d;
    logic [CPW-1:0]      cur_cp_q, cur_cp_d;
    logic [CPW-1:0]      fail_cp_q, fail_cp_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [mem_size-1:0] first_err_q, first_err_d;
    logic [mem_size-1:0] chk_addr_q, chk_addr_d;
    logic [WDW-1:0]      wdog_q, wdog_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;

    cp_t                 cur_ent;
    logic                win_empty;
    logic                out_of_range;
    logic                mismatch;
    logic                wdog_expired;

    // Checkpoint table and golden store: loadable only while idle, never reset.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && !busy_q) begin
            cp_tab[bus.cfg_idx] <= '{pc: bus.cfg_pc, lo: bus.cfg_lo, hi: bus.cfg_hi};
        end
        if (bus.gold_we && !busy_q) begin
            gold_mem[bus.gold_addr] <= bus.gold_data;
        end
    end

    // Control and verdict registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cur_cp_q    <= '0;
            fail_cp_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            chk_addr_q  <= '0;
            wdog_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_cp_q    <= cur_cp_d;
            fail_cp_q   <= fail_cp_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            chk_addr_q  <= chk_addr_d;
            wdog_q      <= wdog_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state: checkpoint sequencing, window scan, watchdog override.
    always_comb begin
        state_d      = state_q;
        cur_cp_d     = cur_cp_q;
        fail_cp_d    = fail_cp_q;
        err_cnt_d    = err_cnt_q;
        first_err_d  = first_err_q;
        chk_addr_d   = chk_addr_q;
        wdog_d       = wdog_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;

        cur_ent      = cp_tab[cur_cp_q];
        win_empty    = cur_ent.lo > cur_ent.hi;
        out_of_range = 32'(chk_addr_q) >= DEPTH;
        mismatch     = out_of_range || (bus.chk_data != gold_mem[GAW'(chk_addr_q)]);
        wdog_expired = (wdog_q == WDW'(TIMEOUT - 1));

        unique case (state_q)
            S_IDLE, S_PASS, S_FAIL, S_TMO: begin
                if (start) begin
                    state_d     = S_WAIT_CP;
                    cur_cp_d    = '0;
                    fail_cp_d   = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    wdog_d      = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            default: begin
                wdog_d = wdog_q + WDW'(1);
                if (wdog_expired) begin
                    state_d   = S_TMO;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    unique case (state_q)
                        S_WAIT_CP: begin
                            if (IM_Address == cur_ent.pc) begin
                                state_d    = S_SCAN;
                                chk_addr_d = cur_ent.lo;
                            end
                        end
                        S_SCAN: begin
                            if (win_empty) begin
                                state_d = S_EVAL;
                            end else begin
                                if (mismatch) begin
                                    if (err_cnt_q != 16'hFFFF) begin
                                        err_cnt_d = err_cnt_q + 16'd1;
                                    end
                                    if (err_cnt_q == '0) begin
                                        first_err_d = chk_addr_q;
                                    end
                                end
                                if (chk_addr_q == cur_ent.hi) begin
                                    state_d = S_EVAL;
                                end else begin
                                    chk_addr_d = chk_addr_q + mem_size'(1);
                                end
                            end
                        end
                        S_EVAL: begin
                            if (err_cnt_q != '0) begin
                                state_d   = S_FAIL;
                                fail_cp_d = cur_cp_q;
                                busy_d    = 1'b0;
                                done_d    = 1'b1;
                            end else if (cur_cp_q == CPW'(NUM_CP - 1)) begin
                                state_d = S_PASS;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                pass_d  = 1'b1;
                            end else begin
                                state_d  = S_WAIT_CP;
                                cur_cp_d = cur_cp_q + CPW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    assign bus.chk_addr    = chk_addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign cur_cp          = cur_cp_q;
    assign fail_cp         = fail_cp_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_addr  = first_err_q;
endmodule

// File: tb/tb_pc_checkpoint_monitor.sv
// Directed bench for pc_checkpoint_monitor: DM model, golden model and a
// verdict scoreboard filled at each start and drained when done rises.
module tb_pc_checkpoint_monitor;
    localparam int unsigned BS  = 32;
    localparam int unsigned MS  = 16;
    localparam int unsigned NCP = 3;
    localparam int unsigned DEP = 32;
    localparam int unsigned TMO = 50;

    typedef struct {
        logic        pass;
        logic        tmo;
        logic [1:0]  fcp;
        logic [15:0] err;
        logic [15:0] fea;
    } verdict_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [MS-1:0] im_addr = '0;
    logic          busy, done, pass, timeout;
    logic [1:0]    cur_cp, fail_cp;
    logic [15:0]   err_cnt;
    logic [MS-1:0] first_err_addr;

    logic [BS-1:0] dm [0:63];
    logic [BS-1:0] gm [0:DEP-1];
    verdict_t      exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    pc_checkpoint_monitor_if #(.bit_size(BS), .mem_size(MS), .NUM_CP(NCP), .DEPTH(DEP)) bif();

    pc_checkpoint_monitor #(
        .bit_size(BS), .mem_size(MS), .NUM_CP(NCP), .DEPTH(DEP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .IM_Address(im_addr), .bus(bif),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .cur_cp(cur_cp), .fail_cp(fail_cp), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr)
    );

    assign bif.chk_data = dm[bif.chk_addr[5:0]];

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "bench hung");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic cfg_write(input int idx, input int pc, input int lo, input int hi);
        bif.cfg_we  = 1'b1;
        bif.cfg_idx = 2'(idx);
        bif.cfg_pc  = MS'(pc);
        bif.cfg_lo  = MS'(lo);
        bif.cfg_hi  = MS'(hi);
        step();
        bif.cfg_we  = 1'b0;
    endtask

    task automatic gold_write(input int a, input logic [BS-1:0] d);
        bif.gold_we   = 1'b1;
        bif.gold_addr = 5'(a);
        bif.gold_data = d;
        step();
        bif.gold_we   = 1'b0;
        gm[a] = d;
    endtask

    task automatic pulse_start(input logic p, input logic t, input int fcp, input int err, input int fea);
        verdict_t v;
        v.pass = p; v.tmo = t; v.fcp = 2'(fcp); v.err = 16'(err); v.fea = 16'(fea);
        exp_q.push_back(v);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic hit(input int pc);
        im_addr = MS'(pc);
        step();
        im_addr = '0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        verdict_t v;
        int n = 0;
        while (!done && n < bound) begin
            step();
            n++;
        end
        check({tag, "_done"}, 64'(done), 64'(1));
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'(1));
        end else begin
            v = exp_q.pop_front();
            check({tag, "_busy"},    64'(busy),           64'(0));
            check({tag, "_pass"},    64'(pass),           64'(v.pass));
            check({tag, "_timeout"}, 64'(timeout),        64'(v.tmo));
            if (!v.pass && !v.tmo) begin
                check({tag, "_fail_cp"}, 64'(fail_cp), 64'(v.fcp));
            end
            check({tag, "_err_cnt"}, 64'(err_cnt),        64'(v.err));
            check({tag, "_first"},   64'(first_err_addr), 64'(v.fea));
        end
    endtask

    task automatic std_table();
        cfg_write(0, 31, 0, 9);
        cfg_write(1, 42, 10, 14);
        cfg_write(2, 60, 20, 20);
    endtask

    // Three in-order checkpoints with clean DM; also checks the scan timing.
    task automatic full_pass_run(input string tag);
        pulse_start(1'b1, 1'b0, 0, 0, 0);
        check({tag, "_busy_after_start"}, 64'(busy), 64'(1));
        hit(31);
        repeat (10) step();
        check({tag, "_cp0_scanning"}, 64'(cur_cp), 64'(0));
        step();
        check({tag, "_cp0_done"}, 64'(cur_cp), 64'(1));
        hit(42);
        repeat (6) step();
        check({tag, "_cp1_done"}, 64'(cur_cp), 64'(2));
        hit(60);
        step();
        check({tag, "_busy_in_eval"}, 64'(busy), 64'(1));
        step();
        wait_done(tag, 0);
    endtask

    initial begin
        bif.cfg_we = 1'b0; bif.cfg_idx = '0; bif.cfg_pc = '0; bif.cfg_lo = '0; bif.cfg_hi = '0;
        bif.gold_we = 1'b0; bif.gold_addr = '0; bif.gold_data = '0;
        for (int i = 0; i < 64; i++) dm[i] = 32'hC0DE0000 ^ BS'(i * 32'h01010101);
        step();
        step();
        check("reset_busy",    64'(busy),              64'(0));
        check("reset_done",    64'(done),              64'(0));
        check("reset_pass",    64'(pass),              64'(0));
        check("reset_timeout", 64'(timeout),           64'(0));
        check("reset_cur_cp",  64'(cur_cp),            64'(0));
        check("reset_fail_cp", 64'(fail_cp),           64'(0));
        check("reset_err_cnt", 64'(err_cnt),           64'(0));
        check("reset_first",   64'(first_err_addr),    64'(0));
        check("reset_chk",     64'(bif.chk_addr),      64'(0));
        rst = 1'b1;
        step();

        for (int i = 0; i < DEP; i++) gold_write(i, dm[i]);
        std_table();

        // Out-of-order PC is ignored, then the normal pass sequence.
        pulse_start(1'b1, 1'b0, 0, 0, 0);
        im_addr = 16'd42;
        repeat (3) step();
        check("order_cur_cp", 64'(cur_cp),       64'(0));
        check("order_chk",    64'(bif.chk_addr), 64'(0));
        hit(31);
        check("order_hit_chk", 64'(bif.chk_addr), 64'(0));
        repeat (11) step();
        check("order_cp1", 64'(cur_cp), 64'(1));
        hit(42);
        repeat (6) step();
        hit(60);
        wait_done("order_pass", 4);

        // Two bad words in checkpoint 1.
        gold_write(12, 32'h5);
        dm[12] = 32'h7;
        dm[13] = gm[13] ^ 32'h1;
        do_reset();
        pulse_start(1'b0, 1'b0, 1, 2, 12);
        hit(31);
        repeat (11) step();
        hit(42);
        wait_done("mismatch", 10);

        // Reset lands in the middle of a 5-word scan.
        cfg_write(0, 31, 10, 14);
        pulse_start(1'b0, 1'b0, 0, 0, 0);
        void'(exp_q.pop_back());
        hit(31);
        repeat (4) step();
        check("midscan_err_cnt", 64'(err_cnt),        64'(2));
        check("midscan_chk",     64'(bif.chk_addr),   64'(14));
        check("midscan_first",   64'(first_err_addr), 64'(12));
        #2 rst = 1'b0;
        #1;
        check("rst_async_busy",  64'(busy),           64'(0));
        check("rst_async_err",   64'(err_cnt),        64'(0));
        check("rst_async_first", 64'(first_err_addr), 64'(0));
        check("rst_async_chk",   64'(bif.chk_addr),   64'(0));
        check("rst_async_done",  64'(done),           64'(0));
        step();
        rst = 1'b1;
        step();
        dm[12] = gm[12];
        dm[13] = gm[13];
        std_table();
        full_pass_run("after_reset");

        // Empty window, plus a table write attempted while busy.
        do_reset();
        cfg_write(0, 31, 5, 3);
        pulse_start(1'b1, 1'b0, 0, 0, 0);
        hit(31);
        check("empty_chk", 64'(bif.chk_addr), 64'(5));
        step();
        check("empty_scan_cp", 64'(cur_cp), 64'(0));
        step();
        check("empty_next_cp", 64'(cur_cp),  64'(1));
        check("empty_err",     64'(err_cnt), 64'(0));
        cfg_write(1, 99, 10, 14);
        hit(42);
        repeat (6) step();
        check("busy_cfg_ignored", 64'(cur_cp), 64'(2));
        hit(60);
        wait_done("empty_window", 5);

        // Window running past the golden store.
        do_reset();
        cfg_write(0, 31, 30, 33);
        cfg_write(1, 42, 10, 14);
        pulse_start(1'b0, 1'b0, 0, 2, 32);
        hit(31);
        wait_done("out_of_range", 8);

        // Watchdog with checkpoint 0 never reached.
        do_reset();
        std_table();
        pulse_start(1'b0, 1'b1, 0, 0, 0);
        repeat (49) step();
        check("wdog_pre_done", 64'(done), 64'(0));
        check("wdog_pre_busy", 64'(busy), 64'(1));
        wait_done("wdog_idle", 1);

        // Watchdog expiring on the final EVAL cycle.
        do_reset();
        cfg_write(0, 31, 0, 0);
        cfg_write(1, 42, 1, 1);
        cfg_write(2, 60, 2, 2);
        pulse_start(1'b0, 1'b1, 0, 0, 0);
        for (int i = 1; i <= 49; i++) begin
            im_addr = (i == 1) ? 16'd31 : (i == 4) ? 16'd42 : (i == 48) ? 16'd60 : 16'd0;
            step();
        end
        im_addr = '0;
        check("wdog_eval_cp",   64'(cur_cp), 64'(2));
        check("wdog_eval_busy", 64'(busy),   64'(1));
        wait_done("wdog_eval", 1);

        // Start re-arms from a terminal state.
        start = 1'b1;
        step();
        start = 1'b0;
        check("rearm_timeout", 64'(timeout), 64'(0));
        check("rearm_done",    64'(done),    64'(0));
        check("rearm_busy",    64'(busy),    64'(1));
        check("rearm_cur_cp",  64'(cur_cp),  64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
